// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from an hs/vs/blank stream
// and tracks lock against the nominal line and frame totals.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [9:0]  HA = 10'(H_ACTIVE);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic [10:0] WD = 11'(2 * H_TOTAL - 1);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [10:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [9:0]  xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic        act_q, act_d, lchk_q, lchk_d;
  logic [9:0]  dx_q, dx_d, dy_q, dy_d;
  logic        pv_q, pv_d, fs_q, fs_d, err_q, err_d;
  logic [10:0] hm_q, hm_d, vm_q, vm_d;

  logic        hs_fall, vs_fall, h_err, v_err, wd_err, err;
  logic [10:0] lcnt_hs;
  logic [9:0]  ycnt_hs;

  always_comb begin
    hs_fall = pix_en & hs_q & ~hs;
    vs_fall = pix_en & vs_q & ~vs;
    lcnt_hs = lcnt_q + {10'd0, hs_fall};
    ycnt_hs = ycnt_q + {9'd0, hs_fall & act_q};
    // lchk_q marks a line that began while checking was already active
    h_err   = hs_fall & lchk_q &
              ((hcnt_q + 11'd1 != HT) | (act_q & (xcnt_q != HA)));
    v_err   = vs_fall & (state_q != SEARCH) &
              ((lcnt_hs != VT) | (ycnt_hs != VA));
    wd_err  = pix_en & ~hs_fall & (state_q != SEARCH) & (hcnt_q == WD);
    err     = h_err | v_err | wd_err;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (err) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (vs_fall) begin
          good_d = good_q + 4'd1;
          if (good_d == LF) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    xcnt_d = xcnt_q;
    ycnt_d = ycnt_q;
    act_d  = act_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    pv_d   = pv_q;
    hm_d   = hm_q;
    vm_d   = vm_q;
    fs_d   = 1'b0;
    err_d  = 1'b0;
    if (pix_en) begin
      hs_d  = hs;
      vs_d  = vs;
      dx_d  = xcnt_q;
      dy_d  = ycnt_q;
      pv_d  = locked & blank;
      fs_d  = (state_q == LOCKED) & vs_fall;
      err_d = err;
      if (hs_fall) begin
        hm_d   = hcnt_q + 11'd1;
        hcnt_d = '0;
        xcnt_d = '0;
        act_d  = 1'b0;
        ycnt_d = ycnt_hs;
        lcnt_d = lcnt_hs;
      end else begin
        hcnt_d = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
        if (blank) begin
          xcnt_d = xcnt_q + 10'd1;
          act_d  = 1'b1;
        end
      end
      if (vs_fall) begin
        vm_d   = lcnt_hs;
        lcnt_d = '0;
        ycnt_d = '0;
      end
    end
    lchk_d = lchk_q;
    if (state_d == SEARCH) lchk_d = 1'b0;
    else if (hs_fall)      lchk_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      xcnt_q  <= '0;
      ycnt_q  <= '0;
      act_q   <= 1'b0;
      lchk_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
      hm_q    <= '0;
      vm_q    <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      xcnt_q  <= xcnt_d;
      ycnt_q  <= ycnt_d;
      act_q   <= act_d;
      lchk_q  <= lchk_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
      hm_q    <= hm_d;
      vm_q    <= vm_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign DrawX       = dx_q;
  assign DrawY       = dy_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign sync_err    = err_q;
  assign h_meas      = hm_q;
  assign v_meas      = vm_q;
endmodule
